// File: rtl/msg_pkg.sv
// Shared constants, scheduler state type and the fixed message ROM
// used by the scrolling message scheduler.
package msg_pkg;
    localparam int CHAR_WIDTH = 8;
    localparam int MSG_LEN    = 11;
    localparam int NUM_MSGS   = 4;
    localparam int SEL_W      = (NUM_MSGS > 1) ? $clog2(NUM_MSGS) : 1;
    localparam logic [CHAR_WIDTH-1:0] BLANK_CHAR = 8'h20;

    typedef enum logic [1:0] {SCROLL, HOLD, PAUSED} sched_state_t;

    localparam logic [MSG_LEN*CHAR_WIDTH-1:0] MSG_ROM [NUM_MSGS] = '{
        "HELLO WORLD",
        "SCROLL TEST",
        "0123456789 ",
        "ABCDEFGHIJK"
    };

    // Character 0 of each message sits in the most significant byte of its ROM word.
    function automatic logic [CHAR_WIDTH-1:0] rom_char(input int msg, input int idx);
        logic [MSG_LEN*CHAR_WIDTH-1:0] word;
        word = MSG_ROM[msg[SEL_W-1:0]];
        word = word >> ((MSG_LEN - 1 - idx) * CHAR_WIDTH);
        return word[CHAR_WIDTH-1:0];
    endfunction
endpackage

// File: rtl/message_scheduler_rise_detect.sv
// Registered single-bit rising-edge detector; the pulse appears one edge
// after the input rises, so a held-high level produces only one pulse.
module rise_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic sig_i,
    output logic rise_o
);
    logic sig_q;
    logic rise_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sig_q  <= 1'b0;
            rise_q <= 1'b0;
        end else begin
            sig_q  <= sig_i;
            rise_q <= sig_i & ~sig_q;
        end
    end

    assign rise_o = rise_q;
endmodule

// File: rtl/message_scheduler.sv
// Scrolls a NUM_DISPLAYS-wide window across a bank of fixed messages, holding
// after each pass. Optional blanking blink during HOLD when MSG_BLINK_EN is defined.
module message_scheduler #(
    parameter int NUM_MSGS     = msg_pkg::NUM_MSGS,
    parameter int MSG_LEN      = msg_pkg::MSG_LEN,
    parameter int CHAR_WIDTH   = msg_pkg::CHAR_WIDTH,
    parameter int NUM_DISPLAYS = 6,
    parameter int HOLD_TICKS   = 3,
    localparam int SEL_W       = (NUM_MSGS > 1) ? $clog2(NUM_MSGS) : 1
) (
    input  logic                                    clk,
    input  logic                                    rst_n,
    input  logic                                    enable,
    input  logic                                    scroll_dir,
    input  logic                                    next_msg,
    input  logic                                    pause_req,
    output logic [NUM_DISPLAYS-1:0][CHAR_WIDTH-1:0] display_chars,
    output logic [SEL_W-1:0]                        msg_sel,
    output logic                                    msg_done,
    output logic                                    paused
);
    localparam int OFF_W  = $clog2(MSG_LEN);
    localparam int HOLD_W = (HOLD_TICKS > 0) ? $clog2(HOLD_TICKS + 1) : 1;

    msg_pkg::sched_state_t state_q, ret_state_q;
    logic [OFF_W-1:0]  offset_q, offset_d;
    logic [SEL_W-1:0]  msg_sel_q, msg_sel_d;
    logic [HOLD_W-1:0] hold_cnt_q;
    logic              msg_done_q;
    logic              paused_q;
    logic              skip_pulse;
    logic [OFF_W:0]    idx;

    rise_detect u_next_rise (
        .clk    (clk),
        .rst_n  (rst_n),
        .sig_i  (next_msg),
        .rise_o (skip_pulse)
    );

    always_comb begin
        if (scroll_dir) begin
            offset_d = (offset_q == OFF_W'(MSG_LEN - 1)) ? '0 : offset_q + OFF_W'(1);
        end else begin
            offset_d = (offset_q == '0) ? OFF_W'(MSG_LEN - 1) : offset_q - OFF_W'(1);
        end
        msg_sel_d = (msg_sel_q == SEL_W'(NUM_MSGS - 1)) ? '0 : msg_sel_q + SEL_W'(1);
    end

    // Window wraps around the message end with a single compare-and-subtract.
    always_comb begin
        idx = '0;
        for (int k = 0; k < NUM_DISPLAYS; k++) begin
            idx = {1'b0, offset_q} + (OFF_W+1)'(k);
            if (idx >= (OFF_W+1)'(MSG_LEN)) begin
                idx = idx - (OFF_W+1)'(MSG_LEN);
            end
            display_chars[NUM_DISPLAYS-1-k] = msg_pkg::rom_char(int'(msg_sel_q), int'(idx));
`ifdef MSG_BLINK_EN
            if (state_q == msg_pkg::HOLD && hold_cnt_q[0]) begin
                display_chars[NUM_DISPLAYS-1-k] = msg_pkg::BLANK_CHAR;
            end
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= msg_pkg::SCROLL;
            ret_state_q <= msg_pkg::SCROLL;
            offset_q    <= '0;
            msg_sel_q   <= '0;
            hold_cnt_q  <= '0;
            msg_done_q  <= 1'b0;
            paused_q    <= 1'b0;
        end else begin
            msg_done_q <= 1'b0;
            if (skip_pulse) begin
                msg_sel_q  <= msg_sel_d;
                offset_q   <= '0;
                hold_cnt_q <= '0;
                if (pause_req) begin
                    state_q     <= msg_pkg::PAUSED;
                    ret_state_q <= msg_pkg::SCROLL;
                    paused_q    <= 1'b1;
                end else begin
                    state_q  <= msg_pkg::SCROLL;
                    paused_q <= 1'b0;
                end
            end else begin
                unique case (state_q)
                    msg_pkg::SCROLL: begin
                        if (pause_req) begin
                            state_q     <= msg_pkg::PAUSED;
                            ret_state_q <= msg_pkg::SCROLL;
                            paused_q    <= 1'b1;
                        end else if (enable) begin
                            offset_q <= offset_d;
                            if (offset_d == '0) begin
                                msg_done_q <= 1'b1;
                                if (HOLD_TICKS == 0) begin
                                    msg_sel_q <= msg_sel_d;
                                end else begin
                                    hold_cnt_q <= HOLD_W'(HOLD_TICKS);
                                    state_q    <= msg_pkg::HOLD;
                                end
                            end
                        end
                    end
                    msg_pkg::HOLD: begin
                        if (pause_req) begin
                            state_q     <= msg_pkg::PAUSED;
                            ret_state_q <= msg_pkg::HOLD;
                            paused_q    <= 1'b1;
                        end else if (enable) begin
                            if (hold_cnt_q <= HOLD_W'(1)) begin
                                hold_cnt_q <= '0;
                                msg_sel_q  <= msg_sel_d;
                                offset_q   <= '0;
                                state_q    <= msg_pkg::SCROLL;
                            end else begin
                                hold_cnt_q <= hold_cnt_q - HOLD_W'(1);
                            end
                        end
                    end
                    msg_pkg::PAUSED: begin
                        if (!pause_req) begin
                            state_q  <= ret_state_q;
                            paused_q <= 1'b0;
                        end
                    end
                    default: begin
                        state_q  <= msg_pkg::SCROLL;
                        paused_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign msg_sel  = msg_sel_q;
    assign msg_done = msg_done_q;
    assign paused   = paused_q;
endmodule

// File: doc/message_scheduler.md
# message_scheduler

Sequencing controller for the scrolling message display. Holds a bank of fixed messages and advances a `NUM_DISPLAYS`-character window across the selected message on each scroll tick from the clock divider. After each complete pass it holds the display for a fixed number of ticks, then moves to the next message. Its window output feeds the per-digit ASCII-to-7-segment converters directly, in place of a single-message scroller.

## Interface

**Parameters**
- `NUM_MSGS`, 4: number of messages in the bank.
- `MSG_LEN`, 11: characters per message.
- `CHAR_WIDTH`, 8: bits per ASCII character.
- `NUM_DISPLAYS`, 6: window width in digits.
- `HOLD_TICKS`, 3: ticks held after each full pass. A value of 0 skips the hold.

**Ports**
- `clk` in 1: system clock (50 MHz).
- `rst_n` in 1: asynchronous, active-low reset.
- `enable` in 1: single-cycle scroll tick from the clock divider.
- `scroll_dir` in 1: 0 = left-to-right, 1 = right-to-left.
- `next_msg` in 1: skip to the next message. Level input; its rising edge is detected internally.
- `pause_req` in 1: level input; freezes scrolling while high.
- `display_chars` out `[CHAR_WIDTH-1:0]` x `NUM_DISPLAYS`: current window. Index `NUM_DISPLAYS-1` is the leftmost digit.
- `msg_sel` out `$clog2(NUM_MSGS)`: index of the active message.
- `msg_done` out 1: one-cycle pulse when a pass completes.
- `paused` out 1: high while in the PAUSED state.

## Operation

**Registers**
- State, `offset` (0..MSG_LEN-1), `msg_sel`, `hold_cnt`, return state, `next_msg` delay flop.

**Window mapping** (combinational from registers)
- `display_chars[NUM_DISPLAYS-1-k] = ROM[msg_sel][(offset+k) mod MSG_LEN]`, for k = 0..NUM_DISPLAYS-1.
- The modulo is computed by compare-and-subtract. No divider.

**States**
- **SCROLL**
  - On `enable`: `scroll_dir=1` increments `offset`, wrapping MSG_LEN-1 to 0. `scroll_dir=0` decrements `offset`, wrapping 0 to MSG_LEN-1.
  - If the new `offset` is 0, a pass is complete: pulse `msg_done`, load `hold_cnt = HOLD_TICKS`, go to HOLD.
  - With `HOLD_TICKS=0`, a completed pass instead advances `msg_sel` directly and stays in SCROLL.
- **HOLD**
  - On `enable`: decrement `hold_cnt`.
  - On the tick where `hold_cnt` reaches 0: `msg_sel` advances (wrapping NUM_MSGS-1 to 0), `offset` = 0, go to SCROLL.
- **PAUSED**
  - Entered from SCROLL or HOLD while `pause_req` is high; the source state is saved.
  - Ticks are ignored.
  - Returns to the saved state in the cycle after `pause_req` falls. `offset` and `hold_cnt` are preserved.

**Priority** (highest first)
1. Reset.
2. `next_msg` rising edge: `msg_sel` advances, `offset` = 0, `hold_cnt` = 0, state becomes SCROLL (or PAUSED if `pause_req` is high), no `msg_done`.
3. `pause_req`.
4. `enable`.
- A tick coinciding with a higher-priority event is dropped.

**Reset values** (reset may occur in any state, including mid-HOLD)
- State SCROLL, `offset` 0, `msg_sel` 0, `hold_cnt` 0.
- `msg_done` 0, `paused` 0.
- `display_chars` = first `NUM_DISPLAYS` characters of message 0.

## Timing

- **Tick to output:** one cycle. After the clock edge that samples `enable=1`, the new `display_chars` and `msg_sel` are valid; no extra pipeline.
- **`msg_done`:** registered; high for exactly the one cycle following the completing tick's edge.
- **`next_msg` latency:**
  - The rising edge is detected by comparison with the delay flop, so a high level repeats nothing.
  - The effect appears two edges after the input rises.
- **Input synchronisation:** `next_msg` and `pause_req` must already be synchronous to `clk`.
- **Tick spacing:** back-to-back `enable` cycles are legal; each is acted on.

## Configuration

- **`MSG_BLINK_EN` defined:** during HOLD, `display_chars` shows all `BLANK_CHAR` (0x20) while `hold_cnt` is odd, and the normal window while it is even.
- **`MSG_BLINK_EN` undefined:** HOLD shows the static window; the blink logic is absent.

## Structure

**Package `msg_pkg`**
- `CHAR_WIDTH`, `MSG_LEN`, `NUM_MSGS`, `BLANK_CHAR`.
- State enum `sched_state_t` {SCROLL, HOLD, PAUSED}.
- Constant ROM, in ASCII:
  - 0 = "HELLO WORLD"
  - 1 = "SCROLL TEST"
  - 2 = "0123456789 "
  - 3 = "ABCDEFGHIJK"

**Sub-module**
- One sub-module `rise_detect`: a single-bit registered edge detector with async active-low reset, instantiated for `next_msg`.

## Test plan

- **Reset:** release reset, no ticks → `display_chars[5..0]` = "HELLO ", `msg_sel`=0, `msg_done`=0.
- **Right-to-left pass and hold:** `scroll_dir=1`, 11 ticks → after tick 1 `[5]`='E'; on tick 11 `msg_done` pulses once. 3 more ticks → `msg_sel`=1, `[5..0]`="SCROLL".
- **Left-to-right wrap:** `scroll_dir=0`, one tick from reset → `offset`=10, `[5]`='D', `[4]`='H'.
- **Skip during hold:** `next_msg` rises mid-HOLD with `msg_sel`=3 → `msg_sel`=0, `offset`=0, state SCROLL, no `msg_done`.
- **Tick collision:** `next_msg` and `enable` in the same cycle → only the message advance occurs.
- **Pause:** `pause_req` high for 5 ticks → outputs frozen, `paused`=1. Release, then 1 tick → scrolling resumes from the frozen `offset`.
- **Async reset in HOLD:** assert `rst_n` low mid-HOLD → all outputs return to reset values immediately, without waiting for a clock edge.
